// File: rtl/cu_fsm_irq.sv
// -----------------------------------------------------------------------------
// cu_fsm_irq
//   Control-unit FSM for the multicycle RISC-V MCU. It sequences instruction
//   fetch, execute, an optional multi-cycle load wait and load writeback, and
//   drives the datapath write/read enables. Level interrupt requests are
//   latched into a pending register. The pending request with the lowest index
//   is taken only after the current instruction has fully committed.
//
// Parameters
//   NUM_IRQ  number of interrupt sources (1..16)
//   RD_LAT   data-memory read latency for loads, in cycles (1..8)
//   IRQ_W    width of the cause field
//
// Ports
//   clk             rising-edge clock
//   RST_N           asynchronous active-low reset
//   opcode, func3   instruction fields ir[6:0] and ir[14:12]
//   irq             level interrupt requests
//   CSR_MSTATUS_MIE global interrupt enable
//   PC_WE, RF_WE, memWE2, csr_WE      write enables
//   memRDEN1, memRDEN2                instruction / data memory read enables
//   reset           active-high datapath reset (asserted in INIT)
//   int_taken       interrupt entry strobe (save MEPC, load MTVEC)
//   mret_exec       MRET strobe
//   irq_cause       index of the interrupt being taken; 0 unless int_taken is 1
//   trap_illegal    illegal-opcode strobe
//
// Build option
//   CU_ILLEGAL_TRAP_EN: when defined, an unrecognised opcode traps into INTR
//   with cause all-ones. When undefined, it executes as a NOP.
// -----------------------------------------------------------------------------
module cu_fsm_irq #(
  parameter int NUM_IRQ = 4,
  parameter int RD_LAT  = 1,
  parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               CSR_MSTATUS_MIE,
  output logic               PC_WE,
  output logic               RF_WE,
  output logic               memWE2,
  output logic               memRDEN1,
  output logic               memRDEN2,
  output logic               reset,
  output logic               csr_WE,
  output logic               int_taken,
  output logic               mret_exec,
  output logic [IRQ_W-1:0]   irq_cause,
  output logic               trap_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    FET  = 3'd1,
    EX   = 3'd2,
    WAIT = 3'd3,
    WB   = 3'd4,
    INTR = 3'd5
  } state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_pend;
  logic [3:0]         r_cnt;
  // Set when the current INTR visit is an illegal-opcode trap rather than an
  // interrupt; such a visit reports cause all-ones and leaves r_pend alone.
  logic               r_trap;

  logic               w_take;
  logic               w_known;
  logic               w_mret;
  logic [IRQ_W-1:0]   w_cause;
  logic [NUM_IRQ-1:0] w_clr;

  assign w_take = (|r_pend) && CSR_MSTATUS_MIE;
  assign w_mret = (opcode == OP_SYS) && (func3 == 3'b000);

  always_comb begin
    w_known = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
      OP_IMM, OP_RG3, OP_JAL, OP_JALR, OP_SYS: w_known = 1'b1;
      default:                                 w_known = 1'b0;
    endcase
  end

  // Fixed priority: scanning from the top lets the lowest set index win.
  always_comb begin
    w_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pend[i]) w_cause = IRQ_W'(i);
    end
  end

  // One-hot clear of the source being serviced. Because irq is ORed back in
  // after the clear, a source still held high stays pending.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
      assign w_clr[gi] = (r_state == INTR) && !r_trap && (w_cause == IRQ_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= INIT;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_trap  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | irq;
      r_trap <= 1'b0;
      case (r_state)
        INIT: r_state <= FET;
        FET:  r_state <= EX;
        EX: begin
          if (opcode == OP_LOAD) begin
            if (RD_LAT > 1) begin
              r_state <= WAIT;
              r_cnt   <= 4'(RD_LAT - 2);
            end else begin
              r_state <= WB;
            end
          end else if (w_mret) begin
            // The interrupt check is deferred by one instruction after MRET.
            r_state <= FET;
          end else if (!w_known) begin
`ifdef CU_ILLEGAL_TRAP_EN
            r_state <= INTR;
            r_trap  <= 1'b1;
`else
            r_state <= FET;
`endif
          end else begin
            r_state <= w_take ? INTR : FET;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= WB;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        WB:      r_state <= w_take ? INTR : FET;
        INTR:    r_state <= FET;
        default: r_state <= INIT;
      endcase
    end
  end

  always_comb begin
    PC_WE        = 1'b0;
    RF_WE        = 1'b0;
    memWE2       = 1'b0;
    memRDEN1     = 1'b0;
    memRDEN2     = 1'b0;
    reset        = 1'b0;
    csr_WE       = 1'b0;
    int_taken    = 1'b0;
    mret_exec    = 1'b0;
    irq_cause    = '0;
    trap_illegal = 1'b0;
    case (r_state)
      INIT: reset    = 1'b1;
      FET:  memRDEN1 = 1'b1;
      EX: begin
        case (opcode)
          OP_LOAD: memRDEN2 = 1'b1;
          OP_STORE: begin
            PC_WE  = 1'b1;
            memWE2 = 1'b1;
          end
          OP_BRANCH: PC_WE = 1'b1;
          OP_LUI, OP_AUIPC, OP_IMM, OP_RG3, OP_JAL, OP_JALR: begin
            PC_WE = 1'b1;
            RF_WE = 1'b1;
          end
          OP_SYS: begin
            PC_WE = 1'b1;
            if (w_mret) begin
              mret_exec = 1'b1;
            end else begin
              RF_WE  = 1'b1;
              csr_WE = 1'b1;
            end
          end
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            trap_illegal = 1'b1;
`else
            PC_WE = 1'b1;
`endif
          end
        endcase
      end
      WAIT: memRDEN2 = 1'b1;
      WB: begin
        PC_WE = 1'b1;
        RF_WE = 1'b1;
      end
      INTR: begin
        int_taken = 1'b1;
        irq_cause = r_trap ? {IRQ_W{1'b1}} : w_cause;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm_irq.sv
`timescale 1ns/1ps
module tb_cu_fsm_irq;

  localparam int NUM_IRQ = 4;
  localparam int RD_LAT  = 3;
  localparam int IRQ_W   = 2;
  localparam int OW      = 10 + IRQ_W;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic               clk = 1'b0;
  logic               RST_N = 1'b0;
  logic [6:0]         opcode = OP_IMM;
  logic [2:0]         func3 = 3'b000;
  logic [NUM_IRQ-1:0] irq = '0;
  logic               mie = 1'b0;
  logic               PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, reset;
  logic               csr_WE, int_taken, mret_exec, trap_illegal;
  logic [IRQ_W-1:0]   irq_cause;
  logic [OW-1:0]      obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the pending set as the spec defines it, plus a flag
  // selecting random or directed interrupt stimulus.
  logic [NUM_IRQ-1:0] m_pend = '0;
  bit                 rnd_irq = 1'b0;

  cu_fsm_irq #(.NUM_IRQ(NUM_IRQ), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .RST_N(RST_N), .opcode(opcode), .func3(func3), .irq(irq),
    .CSR_MSTATUS_MIE(mie), .PC_WE(PC_WE), .RF_WE(RF_WE), .memWE2(memWE2),
    .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .reset(reset), .csr_WE(csr_WE),
    .int_taken(int_taken), .mret_exec(mret_exec), .irq_cause(irq_cause),
    .trap_illegal(trap_illegal)
  );

  assign obs = {PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, reset, csr_WE,
                int_taken, mret_exec, trap_illegal, irq_cause};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc,rf,we2,rd1,rd2,rst,csr,it,mret,trap,cause=%b required %b",
               tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] ev(input bit pc, input bit rf, input bit we2, input bit rd1,
                                       input bit rd2, input bit rst, input bit csr, input bit it,
                                       input bit mr, input bit tr, input logic [IRQ_W-1:0] cause);
    return {pc, rf, we2, rd1, rd2, rst, csr, it, mr, tr, cause};
  endfunction

  function automatic logic [IRQ_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] p);
    for (int i = 0; i < NUM_IRQ; i++) if (p[i]) return IRQ_W'(i);
    return '0;
  endfunction

  function automatic logic [NUM_IRQ-1:0] pick_irq(input bit at_ex, input logic [NUM_IRQ-1:0] ex_irq);
    if (rnd_irq) return ($urandom_range(0, 5) == 0) ? NUM_IRQ'($urandom) : '0;
    return at_ex ? ex_irq : '0;
  endfunction

  // One clock cycle: apply irq, check outputs at the falling edge, then
  // advance the pending model on the rising edge. Entered at posedge+1.
  task automatic run_cycle(input string tag, input logic [OW-1:0] exp,
                           input logic [NUM_IRQ-1:0] clr, input logic [NUM_IRQ-1:0] irq_v);
    irq = irq_v;
    @(negedge clk);
    check_eq(tag, obs, exp);
    @(posedge clk);
    m_pend = (m_pend & ~clr) | irq_v;
    #1;
  endtask

  task automatic do_reset(input int n);
    RST_N  = 1'b0;
    irq    = '0;
    m_pend = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq("reset_hold", obs, ev(0,0,0,0,0,1,0,0,0,0,'0));
      @(posedge clk);
      #1;
    end
    RST_N = 1'b1;
    run_cycle("init", ev(0,0,0,0,0,1,0,0,0,0,'0), '0, '0);
  endtask

  // One whole instruction, followed by the interrupt/trap entry the rules imply.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [NUM_IRQ-1:0] ex_irq);
    bit take, is_load, trap, to_intr;
    logic [OW-1:0] e;
    logic [IRQ_W-1:0] c;
    opcode  = op;
    func3   = f3;
    to_intr = 1'b0;
    trap    = 1'b0;
    is_load = 1'b0;
    run_cycle("fetch", ev(0,0,0,1,0,0,0,0,0,0,'0), '0, pick_irq(0, ex_irq));
    take = (m_pend != '0) && mie;
    case (op)
      OP_LOAD: begin
        is_load = 1'b1;
        e = ev(0,0,0,0,1,0,0,0,0,0,'0);
      end
      OP_STORE: begin
        e = ev(1,0,1,0,0,0,0,0,0,0,'0);
        to_intr = take;
      end
      OP_BRANCH: begin
        e = ev(1,0,0,0,0,0,0,0,0,0,'0);
        to_intr = take;
      end
      OP_LUI, OP_AUIPC, OP_IMM, OP_RG3, OP_JAL, OP_JALR: begin
        e = ev(1,1,0,0,0,0,0,0,0,0,'0);
        to_intr = take;
      end
      OP_SYS: begin
        if (f3 == 3'b000) begin
          e = ev(1,0,0,0,0,0,0,0,1,0,'0);
        end else begin
          e = ev(1,1,0,0,0,0,1,0,0,0,'0);
          to_intr = take;
        end
      end
      default: begin
`ifdef CU_ILLEGAL_TRAP_EN
        e = ev(0,0,0,0,0,0,0,0,0,1,'0);
        trap = 1'b1;
        to_intr = 1'b1;
`else
        e = ev(1,0,0,0,0,0,0,0,0,0,'0);
`endif
      end
    endcase
    run_cycle("execute", e, '0, pick_irq(1, ex_irq));
    if (is_load) begin
      for (int k = 0; k < RD_LAT - 1; k++)
        run_cycle("load_wait", ev(0,0,0,0,1,0,0,0,0,0,'0), '0, pick_irq(0, ex_irq));
      take = (m_pend != '0) && mie;
      run_cycle("writeback", ev(1,1,0,0,0,0,0,0,0,0,'0), '0, pick_irq(0, ex_irq));
      to_intr = take;
    end
    if (to_intr) begin
      if (trap) begin
        run_cycle("trap_entry", ev(0,0,0,0,0,0,0,1,0,0,{IRQ_W{1'b1}}), '0, pick_irq(0, ex_irq));
      end else begin
        c = lowest_set(m_pend);
        run_cycle("irq_entry", ev(0,0,0,0,0,0,0,1,0,0,c), NUM_IRQ'(1) << c, pick_irq(0, ex_irq));
      end
    end
  endtask

  logic [6:0] op_tab [12];

  initial begin
    op_tab = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_IMM,
               OP_RG3, OP_JAL, OP_JALR, OP_SYS, OP_SYS, OP_BAD};
    @(posedge clk);
    #1;
    do_reset(3);

    // Plain sequencing with interrupts enabled but none requested.
    mie = 1'b1;
    do_instr(OP_IMM, 3'b000, '0);
    do_instr(OP_STORE, 3'b010, '0);
    do_instr(OP_LOAD, 3'b010, '0);

    // Two sources raised together: serviced one per boundary, index 1 first.
    do_instr(OP_LUI, 3'b000, 4'b1010);
    do_instr(OP_IMM, 3'b000, '0);
    do_instr(OP_RG3, 3'b000, '0);
    do_instr(OP_BRANCH, 3'b000, '0);

    // Masked request stays pending until MIE returns.
    mie = 1'b0;
    do_instr(OP_IMM, 3'b000, 4'b0100);
    for (int k = 0; k < 10; k++) do_instr(OP_AUIPC, 3'b000, '0);
    mie = 1'b1;
    do_instr(OP_JAL, 3'b000, '0);
    do_instr(OP_IMM, 3'b000, '0);

    // MRET defers the check; CSR op and illegal opcode.
    do_instr(OP_IMM, 3'b000, 4'b0001);
    do_instr(OP_SYS, 3'b000, '0);
    do_instr(OP_SYS, 3'b001, '0);
    do_instr(OP_BAD, 3'b000, '0);
    do_instr(OP_IMM, 3'b000, '0);

    // Randomised mix of opcodes, requests and MIE.
    rnd_irq = 1'b1;
    for (int n = 0; n < 300; n++) begin
      mie = ($urandom_range(0, 4) != 0);
      do_instr(op_tab[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), '0);
    end

    // Reset in the middle of a load wait discards the instruction and pending set.
    rnd_irq = 1'b0;
    mie     = 1'b1;
    opcode  = OP_LOAD;
    func3   = 3'b000;
    run_cycle("fetch", ev(0,0,0,1,0,0,0,0,0,0,'0), '0, 4'b0100);
    run_cycle("execute", ev(0,0,0,0,1,0,0,0,0,0,'0), '0, '0);
    do_reset(1);
    do_instr(OP_IMM, 3'b000, '0);
    do_instr(OP_STORE, 3'b000, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
